// File: rtl/pop_rr_c_if.sv
// ============================================================================
// Module      : pop_rr_c_if
// Description : Bundle of FIFO-side inputs and downstream outputs of pop_rr_c.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pop_rr_c_if #(
    parameter int DW = 6
);
    logic [3:0]    fifo_empty;
    logic [3:0]    fifo_almost_full;
    logic [3:0]    fifo_error;
    logic [3:0]    valid_in;
    logic [DW-1:0] data_in0;
    logic [DW-1:0] data_in1;
    logic [DW-1:0] data_in2;
    logic [DW-1:0] data_in3;
    logic          pause_in;
    logic [3:0]    pop;
    logic [DW-1:0] data_out;
    logic          push_out;
    logic [1:0]    sel_out;
    logic          idle;
    logic          error_out;

    // Master drives the FIFO status/data side and observes the arbiter.
    modport master (
        output fifo_empty, fifo_almost_full, fifo_error, valid_in,
        output data_in0, data_in1, data_in2, data_in3, pause_in,
        input  pop, data_out, push_out, sel_out, idle, error_out
    );

    modport slave (
        input  fifo_empty, fifo_almost_full, fifo_error, valid_in,
        input  data_in0, data_in1, data_in2, data_in3, pause_in,
        output pop, data_out, push_out, sel_out, idle, error_out
    );
endinterface

`default_nettype wire

// File: rtl/pop_rr_c.sv
// ============================================================================
// Module      : pop_rr_c
// Description : Four-FIFO pop arbiter, almost-full priority then round-robin.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pop_rr_c #(
    parameter int DW = 6,
    parameter int N  = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pop_rr_c_if.slave   bus
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_IDLE   = 5'b00010,
        ST_ACTIVE = 5'b00100,
        ST_PAUSE  = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    last_q;
    logic [DW-1:0] data_q;
    logic          push_q;
    logic [1:0]    sel_q;

    logic [N-1:0]  nonempty;
    logic          af_any;
    logic [1:0]    af_idx;
    logic          rr_any;
    logic [1:0]    rr_idx;
    logic [1:0]    cand;
    logic          gnt_any;
    logic [1:0]    gnt_idx;
    logic          pop_en;
    logic          pop_fire;
    logic [DW-1:0] data_sel;

    assign nonempty = ~bus.fifo_empty;

    // Descending loops let the lowest index / shortest offset overwrite last.
    always_comb begin
        af_any = 1'b0;
        af_idx = 2'd0;
        rr_any = 1'b0;
        rr_idx = 2'd0;
        cand   = 2'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (nonempty[i] && bus.fifo_almost_full[i]) begin
                af_any = 1'b1;
                af_idx = 2'(i);
            end
        end
        for (int k = N; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (nonempty[cand]) begin
                rr_any = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign gnt_any = af_any | rr_any;
    assign gnt_idx = af_any ? af_idx : rr_idx;

    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.pause_in) begin
                    state_d = ST_PAUSE;
                end else if (|nonempty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                pop_en = 1'b1;
                if (bus.pause_in) begin
                    state_d = ST_PAUSE;
                end else if (~|nonempty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (!bus.pause_in) begin
                    state_d = (|nonempty) ? ST_ACTIVE : ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
        if ((state_q != ST_RESET) && (|bus.fifo_error)) begin
            state_d = ST_ERROR;
        end
    end

    assign pop_fire = pop_en && gnt_any && !bus.pause_in && !reset;

    always_comb begin
        data_sel = bus.data_in0;
        case (gnt_idx)
            2'd0:    data_sel = bus.data_in0;
            2'd1:    data_sel = bus.data_in1;
            2'd2:    data_sel = bus.data_in2;
            default: data_sel = bus.data_in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            last_q  <= 2'd3;
            data_q  <= '0;
            push_q  <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (pop_fire) begin
                last_q <= gnt_idx;
            end
            // A grant without valid data still advances last_q but pushes nothing.
            push_q <= pop_fire && bus.valid_in[gnt_idx];
            if (pop_fire && bus.valid_in[gnt_idx]) begin
                data_q <= data_sel;
                sel_q  <= gnt_idx;
            end
        end
    end

    assign bus.pop       = pop_fire ? (N'(1) << gnt_idx) : '0;
    assign bus.data_out  = data_q;
    assign bus.push_out  = push_q;
    assign bus.sel_out   = sel_q;
    assign bus.idle      = (state_q == ST_IDLE) && !reset;
    assign bus.error_out = (state_q == ST_ERROR) && !reset;

endmodule

`default_nettype wire
